// File: rtl/jtdsp16_sout.sv
// DSP16 serial output port: write FIFO, 8/16-bit words in either bit order, OCK divider.
// Define JTDSP16_SOUT_SADD_EN to also shift the SRTA address out on SADD.
module jtdsp16_sout #(
    parameter int DEPTH = 4,
    parameter int CKDIV = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cen,
    input  logic [15:0]                long_imm,
    input  logic                       sio_imm_load,
    input  logic [2:0]                 r_field,
    output logic                       ock,
    output logic                       sio_do,
    output logic                       old,
    output logic                       sadd,
    output logic                       ose,
    output logic                       obe,
    output logic                       ofull,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(CKDIV);
`ifdef JTDSP16_SOUT_SADD_EN
    localparam int FW = 24;
`else
    localparam int FW = 16;
`endif

    typedef enum logic { IDLE, SHIFT } state_t;

    state_t          state;
    logic [9:0]      sioc;
    logic [FW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic [CW-1:0]   clkdiv;
    logic [15:0]     shifter;
    logic [4:0]      bitcnt;
    logic            w8, msb;
    logic [FW-1:0]   entry, head;
    logic            boundary, push, pop, push_ok, fifo_empty, fifo_full;

    // Remaining SIOC bits are kept for read-back compatibility only
    logic unused_sioc;
    assign unused_sioc = &{1'b0, sioc[9:7], sioc[5:2], sioc[0]};

`ifdef JTDSP16_SOUT_SADD_EN
    logic [7:0] srta;
    logic [7:0] addrsh;
    assign entry = {srta, long_imm};
    assign sadd  = (state == SHIFT) && addrsh[7];
`else
    assign entry = long_imm;
    assign sadd  = 1'b0;
`endif

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LW'(DEPTH));
    assign boundary   = cen && (clkdiv == CW'(CKDIV-1));
    assign push       = cen && sio_imm_load && (r_field == 3'd2);
    assign pop        = boundary && !fifo_empty && (state == IDLE || bitcnt == 5'd1);
    // A full FIFO still accepts a push when the shifter pops the head on the same edge
    assign push_ok    = push && (!fifo_full || pop);

    assign ock    = (state == SHIFT) && (clkdiv >= CW'(CKDIV/2));
    assign sio_do = (state == SHIFT) && (msb ? (w8 ? shifter[7] : shifter[15]) : shifter[0]);
    assign ose    = (state == IDLE) && fifo_empty;
    assign obe    = fifo_empty;
    assign ofull  = fifo_full;
    assign level  = count;

    // Data path: FIFO storage and word shifters, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry;
        if (pop) begin
            shifter <= head[15:0];
`ifdef JTDSP16_SOUT_SADD_EN
            addrsh  <= head[23:16];
`endif
        end else if (boundary && state == SHIFT) begin
            shifter <= msb ? {shifter[14:0], 1'b0} : {1'b0, shifter[15:1]};
`ifdef JTDSP16_SOUT_SADD_EN
            addrsh  <= {addrsh[6:0], 1'b1};
`endif
        end
    end

    // Control: registers, FIFO pointers, divider and FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sioc   <= 10'h2E8;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            clkdiv <= '0;
            ovf    <= 1'b0;
            old    <= 1'b1;
            bitcnt <= '0;
            w8     <= 1'b0;
            msb    <= 1'b1;
`ifdef JTDSP16_SOUT_SADD_EN
            srta   <= '0;
`endif
        end else if (cen) begin
            clkdiv <= boundary ? '0 : clkdiv + CW'(1);
            if (sio_imm_load && r_field == 3'd0) begin
                sioc <= long_imm[9:0];
                ovf  <= 1'b0;
            end
`ifdef JTDSP16_SOUT_SADD_EN
            if (sio_imm_load && r_field == 3'd1) srta <= long_imm[7:0];
`endif
            if (push && !push_ok) ovf <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{(LW-1){1'b0}}, push_ok} - {{(LW-1){1'b0}}, pop};

            if (pop) begin
                state  <= SHIFT;
                old    <= 1'b0;
                w8     <= sioc[1];
                msb    <= sioc[6];
                bitcnt <= sioc[1] ? 5'd8 : 5'd16;
            end else if (state == SHIFT && boundary) begin
                if (bitcnt == 5'd1) begin
                    state <= IDLE;
                    old   <= 1'b1;
                end else begin
                    bitcnt <= bitcnt - 5'd1;
                end
            end
        end
    end
endmodule
